// File: rtl/fp_div_unit_pkg.sv
// Shared constants, FSM encoding and operand classification for the FDIV.S unit.
package fp_div_unit_pkg;

    localparam logic [31:0] FP_CANON_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;
    localparam int          FP_BIAS       = 127;
    localparam int          ITER_BITS_DEF = 26;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ITER   = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

    // Subnormals (exponent field 0) classify as zero: the unit flushes them.
    function automatic fp_class_t fp_classify(input logic [30:0] x);
        fp_class_t c;
        c.is_zero = (x[30:23] == 8'h00);
        c.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        c.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        c.is_snan = c.is_nan && !x[22];
        return c;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational round-to-nearest-even, overflow/flush-to-zero and binary32 packing.
module fp_div_round #(
    parameter int EXP_W = 10
) (
    input  logic                    i_sign,
    input  logic signed [EXP_W-1:0] i_exp,
    input  logic [23:0]             i_quo,
    input  logic                    i_guard,
    input  logic                    i_round,
    input  logic                    i_sticky,
    output logic [31:0]             o_word,
    output logic                    o_of,
    output logic                    o_uf,
    output logic                    o_nx
);

    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

    logic                    w_inc;
    logic [24:0]             w_sum;
    logic signed [EXP_W-1:0] w_exp;
    logic [22:0]             w_frac;

    assign w_inc  = i_guard & (i_round | i_sticky | i_quo[0]);
    assign w_sum  = {1'b0, i_quo} + 25'(w_inc);
    // Carry out of the significand only happens for 1.111..1 rounding up to 10.000..0.
    assign w_exp  = w_sum[24] ? (i_exp + EXP_ONE) : i_exp;
    assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

    always_comb begin
        o_of   = 1'b0;
        o_uf   = 1'b0;
        o_word = {i_sign, w_exp[7:0], w_frac};
        if (w_exp >= EXP_MAX) begin
            o_of   = 1'b1;
            o_word = {i_sign, 8'hFF, 23'd0};
        end else if (w_exp <= EXP_ZERO) begin
            o_uf   = 1'b1;
            o_word = {i_sign, 31'd0};
        end
    end

    assign o_nx = i_guard | i_round | i_sticky | o_of | o_uf;

endmodule

// File: rtl/fp_div_unit.sv
// Iterative FDIV.S unit (radix-2 restoring, RNE, flush-to-zero) with valid/ready write-back.
// Optional IEEE exception flags output oFFlags enabled by defining FDIV_FLAGS_EN.
module fp_div_unit
    import fp_div_unit_pkg::*;
#(
    parameter int ITER_BITS = ITER_BITS_DEF,
    parameter int EXP_W     = 10
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [31:0] iRs1Data,
    input  logic [31:0] iRs2Data,
    input  logic [4:0]  iRd,
    input  logic        iWbReady,
    output logic        oBusy,
    output logic        oWbValid,
    output logic        oRegWrite,
    output logic [4:0]  oWriteRegister,
    output logic [31:0] oWriteData
`ifdef FDIV_FLAGS_EN
    ,
    output logic [4:0]  oFFlags
`endif
);

    localparam logic signed [EXP_W-1:0] BIAS_E  = EXP_W'(FP_BIAS);
    localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    state_t                  r_state;
    logic [31:0]             r_a;
    logic [31:0]             r_b;
    logic [4:0]              r_rd;
    logic                    r_sign;
    logic signed [EXP_W-1:0] r_exp;
    logic [24:0]             r_rem;
    logic [23:0]             r_div;
    logic [ITER_BITS-1:0]    r_quo;
    logic [4:0]              r_cnt;
    logic                    r_sticky;
    logic                    r_spec_vld;
    logic [31:0]             r_spec_val;
    logic [31:0]             r_result;
    logic                    r_wb_valid;

    fp_class_t               w_cls_a;
    fp_class_t               w_cls_b;
    logic signed [EXP_W-1:0] w_exp_a;
    logic signed [EXP_W-1:0] w_exp_b;
    logic                    w_sign;
    logic                    w_spec_vld;
    logic [31:0]             w_spec_val;
    logic [25:0]             w_diff;
    logic                    w_ge;
    logic [31:0]             w_rnd_word;
    logic                    w_of;
    logic                    w_uf;
    logic                    w_nx;

    assign w_cls_a = fp_classify(r_a[30:0]);
    assign w_cls_b = fp_classify(r_b[30:0]);
    assign w_exp_a = $signed({{(EXP_W-8){1'b0}}, r_a[30:23]});
    assign w_exp_b = $signed({{(EXP_W-8){1'b0}}, r_b[30:23]});
    assign w_sign  = r_a[31] ^ r_b[31];

    always_comb begin
        w_spec_vld = 1'b1;
        w_spec_val = 32'd0;
        if (w_cls_a.is_nan || w_cls_b.is_nan) begin
            w_spec_val = FP_CANON_NAN;
        end else if ((w_cls_a.is_zero && w_cls_b.is_zero) || (w_cls_a.is_inf && w_cls_b.is_inf)) begin
            w_spec_val = FP_CANON_NAN;
        end else if (w_cls_a.is_inf || w_cls_b.is_zero) begin
            w_spec_val = {w_sign, FP_POS_INF[30:0]};
        end else if (w_cls_a.is_zero || w_cls_b.is_inf) begin
            w_spec_val = {w_sign, 31'd0};
        end else begin
            w_spec_vld = 1'b0;
        end
    end

    // Remainder never exceeds twice the divisor, so 26 bits hold the trial difference.
    assign w_diff = {1'b0, r_rem} - {2'b00, r_div};
    assign w_ge   = ~w_diff[25];

    fp_div_round #(
        .EXP_W(EXP_W)
    ) u_round (
        .i_sign  (r_sign),
        .i_exp   (r_exp),
        .i_quo   (r_quo[ITER_BITS-1 -: 24]),
        .i_guard (r_quo[ITER_BITS-25]),
        .i_round (r_quo[ITER_BITS-26]),
        .i_sticky(r_sticky),
        .o_word  (w_rnd_word),
        .o_of    (w_of),
        .o_uf    (w_uf),
        .o_nx    (w_nx)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_spec_vld <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_a     <= iRs1Data;
                        r_b     <= iRs2Data;
                        r_rd    <= iRd;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign     <= w_sign;
                    r_exp      <= w_exp_a - w_exp_b + BIAS_E;
                    r_rem      <= {2'b01, r_a[22:0]};
                    r_div      <= {1'b1, r_b[22:0]};
                    r_quo      <= '0;
                    r_cnt      <= '0;
                    r_spec_vld <= w_spec_vld;
                    r_spec_val <= w_spec_val;
                    r_state    <= S_ITER;
                end
                S_ITER: begin
                    r_quo <= {r_quo[ITER_BITS-2:0], w_ge};
                    r_rem <= w_ge ? {w_diff[23:0], 1'b0} : {r_rem[23:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(ITER_BITS - 1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (!r_quo[ITER_BITS-1]) begin
                        r_quo <= {r_quo[ITER_BITS-2:0], 1'b0};
                        r_exp <= r_exp - EXP_ONE;
                    end
                    r_sticky <= |r_rem;
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_result   <= r_spec_vld ? r_spec_val : w_rnd_word;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_WB;
                end
                S_WB: begin
                    if (iWbReady) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oBusy          = (r_state != S_IDLE);
    assign oWbValid       = r_wb_valid;
    assign oRegWrite      = r_wb_valid & iWbReady;
    assign oWriteRegister = r_rd;
    assign oWriteData     = r_result;

`ifdef FDIV_FLAGS_EN
    logic       w_nv;
    logic       w_dz;
    logic [1:0] r_spec_flags;
    logic [4:0] r_flags;

    always_comb begin
        w_nv = 1'b0;
        w_dz = 1'b0;
        if (w_cls_a.is_nan || w_cls_b.is_nan) begin
            w_nv = w_cls_a.is_snan | w_cls_b.is_snan;
        end else if ((w_cls_a.is_zero && w_cls_b.is_zero) || (w_cls_a.is_inf && w_cls_b.is_inf)) begin
            w_nv = 1'b1;
        end else begin
            w_dz = !w_cls_a.is_inf && w_cls_b.is_zero;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_spec_flags <= '0;
            r_flags      <= '0;
        end else if (r_state == S_UNPACK) begin
            r_spec_flags <= {w_nv, w_dz};
        end else if (r_state == S_ROUND) begin
            r_flags <= r_spec_vld ? {r_spec_flags, 3'b000} : {2'b00, w_of, w_uf, w_nx};
        end
    end

    assign oFFlags = r_wb_valid ? r_flags : 5'd0;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{w_of, w_uf, w_nx, w_cls_a.is_snan, w_cls_b.is_snan};
`endif

endmodule
